// File: rtl/global_config_pkg.sv
// Shared D-cache configuration and decode types used by the D-cache memory-side blocks.
package global_config_pkg;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned DCACHE_LINE_WIDTH;
    int unsigned DCACHE_SET_ASSOC_WIDTH;
    int unsigned DCACHE_INDEX_WIDTH;
  } cfg_t;

  // 32-bit physical addresses, 64-byte lines, 4-way, 64 sets.
  localparam cfg_t Cfg = '{
    PLEN:                   32,
    DCACHE_LINE_WIDTH:      512,
    DCACHE_SET_ASSOC_WIDTH: 2,
    DCACHE_INDEX_WIDTH:     6
  };

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    REFILL  = 3'd5
  } dcache_mem_state_e;

  function automatic int unsigned line_offset_w(input cfg_t c);
    return $clog2(c.DCACHE_LINE_WIDTH / 8);
  endfunction

endpackage

// File: rtl/dcache_mem_ctrl.sv
// D-cache line mover: serialises writebacks and miss refills onto a single-outstanding
// memory port, writeback first so dirty victims land in memory before any re-read.
module dcache_mem_ctrl #(
  parameter global_config_pkg::cfg_t Cfg = global_config_pkg::Cfg
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      miss_req_valid_i,
  output logic                                      miss_req_ready_o,
  input  logic [Cfg.PLEN-1:0]                       miss_req_paddr_i,
  input  logic [Cfg.DCACHE_SET_ASSOC_WIDTH-1:0]     miss_req_victim_way_i,
  input  logic [Cfg.DCACHE_INDEX_WIDTH-1:0]         miss_req_index_i,
  input  logic                                      wb_req_valid_i,
  output logic                                      wb_req_ready_o,
  input  logic [Cfg.PLEN-1:0]                       wb_req_paddr_i,
  input  logic [Cfg.DCACHE_LINE_WIDTH-1:0]          wb_req_data_i,
  output logic                                      refill_valid_o,
  input  logic                                      refill_ready_i,
  output logic [Cfg.PLEN-1:0]                       refill_paddr_o,
  output logic [Cfg.DCACHE_SET_ASSOC_WIDTH-1:0]     refill_way_o,
  output logic [Cfg.DCACHE_LINE_WIDTH-1:0]          refill_data_o,
  output logic                                      mem_req_valid_o,
  input  logic                                      mem_req_ready_i,
  output logic                                      mem_req_we_o,
  output logic [Cfg.PLEN-1:0]                       mem_req_addr_o,
  output logic [Cfg.DCACHE_LINE_WIDTH-1:0]          mem_req_wdata_o,
  input  logic                                      mem_resp_valid_i,
  input  logic [Cfg.DCACHE_LINE_WIDTH-1:0]          mem_resp_data_i,
  output logic                                      busy_o
);
  import global_config_pkg::*;

  localparam int unsigned PLEN  = Cfg.PLEN;
  localparam int unsigned LINE  = Cfg.DCACHE_LINE_WIDTH;
  localparam int unsigned WAYW  = Cfg.DCACHE_SET_ASSOC_WIDTH;
  localparam int unsigned IDXW  = Cfg.DCACHE_INDEX_WIDTH;
  localparam int unsigned OFF_W = line_offset_w(Cfg);

  dcache_mem_state_e r_state;
  dcache_mem_state_e w_state_nxt;

  logic            w_wb_acc;
  logic            w_miss_acc;
  logic            w_rd_capture;

  logic [PLEN-1:0] r_paddr;
  logic [WAYW-1:0] r_way;
  logic [IDXW-1:0] r_unused_index;
  logic [LINE-1:0] r_wdata;
  logic [LINE-1:0] r_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Responses are only looked at in the WAIT states, so a pulse coinciding with the
  // request fire (still in a REQ state) or arriving while idle/refilling is dropped.
  always_comb begin
    w_state_nxt      = r_state;
    wb_req_ready_o   = 1'b0;
    miss_req_ready_o = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_req_we_o     = 1'b0;
    refill_valid_o   = 1'b0;
    w_wb_acc         = 1'b0;
    w_miss_acc       = 1'b0;
    w_rd_capture     = 1'b0;
    case (r_state)
      IDLE: begin
        wb_req_ready_o   = 1'b1;
        miss_req_ready_o = !wb_req_valid_i;
        if (wb_req_valid_i) begin
          w_wb_acc    = 1'b1;
          w_state_nxt = WB_REQ;
        end else if (miss_req_valid_i) begin
          w_miss_acc  = 1'b1;
          w_state_nxt = RD_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        if (mem_req_ready_i) w_state_nxt = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_resp_valid_i) w_state_nxt = IDLE;
      end
      RD_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_resp_valid_i) begin
          w_rd_capture = 1'b1;
          w_state_nxt  = REFILL;
        end
      end
      REFILL: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One address register serves both directions: only one transaction is ever live.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_paddr        <= '0;
      r_way          <= '0;
      r_unused_index <= '0;
      r_wdata        <= '0;
      r_rdata        <= '0;
    end else begin
      if (w_wb_acc) begin
        r_paddr <= wb_req_paddr_i;
        r_wdata <= wb_req_data_i;
      end
      if (w_miss_acc) begin
        r_paddr        <= miss_req_paddr_i;
        r_way          <= miss_req_victim_way_i;
        r_unused_index <= miss_req_index_i;
      end
      if (w_rd_capture) begin
        r_rdata <= mem_resp_data_i;
      end
    end
  end

  assign mem_req_addr_o  = {r_paddr[PLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_req_wdata_o = r_wdata;
  assign refill_paddr_o  = r_paddr;
  assign refill_way_o    = r_way;
  assign refill_data_o   = r_rdata;
  assign busy_o          = (r_state != IDLE);

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Randomised bench for dcache_mem_ctrl: a transaction-level model predicts request order,
// memory request contents, refill contents and refill latency for each scenario.
module tb_dcache_mem_ctrl;
  import global_config_pkg::*;

  localparam int PLEN = Cfg.PLEN;
  localparam int LINE = Cfg.DCACHE_LINE_WIDTH;
  localparam int WAYW = Cfg.DCACHE_SET_ASSOC_WIDTH;
  localparam int IDXW = Cfg.DCACHE_INDEX_WIDTH;
  localparam int LINE_BYTES = LINE / 8;

  typedef logic [LINE-1:0] line_t;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            miss_req_valid_i;
  logic            miss_req_ready_o;
  logic [PLEN-1:0] miss_req_paddr_i;
  logic [WAYW-1:0] miss_req_victim_way_i;
  logic [IDXW-1:0] miss_req_index_i;
  logic            wb_req_valid_i;
  logic            wb_req_ready_o;
  logic [PLEN-1:0] wb_req_paddr_i;
  logic [LINE-1:0] wb_req_data_i;
  logic            refill_valid_o;
  logic            refill_ready_i;
  logic [PLEN-1:0] refill_paddr_o;
  logic [WAYW-1:0] refill_way_o;
  logic [LINE-1:0] refill_data_o;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic            mem_req_we_o;
  logic [PLEN-1:0] mem_req_addr_o;
  logic [LINE-1:0] mem_req_wdata_o;
  logic            mem_resp_valid_i;
  logic [LINE-1:0] mem_resp_data_i;
  logic            busy_o;

  dcache_mem_ctrl #(.Cfg(Cfg)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .miss_req_valid_i      (miss_req_valid_i),
    .miss_req_ready_o      (miss_req_ready_o),
    .miss_req_paddr_i      (miss_req_paddr_i),
    .miss_req_victim_way_i (miss_req_victim_way_i),
    .miss_req_index_i      (miss_req_index_i),
    .wb_req_valid_i        (wb_req_valid_i),
    .wb_req_ready_o        (wb_req_ready_o),
    .wb_req_paddr_i        (wb_req_paddr_i),
    .wb_req_data_i         (wb_req_data_i),
    .refill_valid_o        (refill_valid_o),
    .refill_ready_i        (refill_ready_i),
    .refill_paddr_o        (refill_paddr_o),
    .refill_way_o          (refill_way_o),
    .refill_data_o         (refill_data_o),
    .mem_req_valid_o       (mem_req_valid_o),
    .mem_req_ready_i       (mem_req_ready_i),
    .mem_req_we_o          (mem_req_we_o),
    .mem_req_addr_o        (mem_req_addr_o),
    .mem_req_wdata_o       (mem_req_wdata_o),
    .mem_resp_valid_i      (mem_resp_valid_i),
    .mem_resp_data_i       (mem_resp_data_i),
    .busy_o                (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input line_t got, input line_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < LINE / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Line base address computed arithmetically: address minus its byte offset in the line.
  function automatic logic [PLEN-1:0] line_base(input logic [PLEN-1:0] a);
    logic [PLEN-1:0] off;
    off = a % PLEN'(LINE_BYTES);
    return a - off;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Scenario description
  bit              s_wb, s_miss;
  logic [PLEN-1:0] s_wb_addr, s_miss_addr;
  line_t           s_wb_data, s_rdata;
  logic [WAYW-1:0] s_way;
  logic [IDXW-1:0] s_idx;
  int              s_kw, s_dw, s_kr, s_dr, s_rr;
  bit              miss_pend;

  task automatic serve_mem(input bit we, input logic [PLEN-1:0] exp_addr, input line_t exp_wdata,
                           input int k, input int d, input line_t rdata);
    for (int i = 0; i <= k; i++) begin
      tick();
      wb_req_valid_i   = 1'b0;
      miss_req_valid_i = miss_pend;
      refill_ready_i   = $urandom_range(0, 1);
      mem_req_ready_i  = (i == k);
      mem_resp_valid_i = $urandom_range(0, 1);
      mem_resp_data_i  = rand_line();
      settle();
      chk("mem_req_valid", line_t'(mem_req_valid_o), line_t'(1'b1));
      chk("mem_req_we", line_t'(mem_req_we_o), line_t'(we));
      chk("mem_req_addr", line_t'(mem_req_addr_o), line_t'(exp_addr));
      if (we) chk("mem_req_wdata", mem_req_wdata_o, exp_wdata);
      chk("busy_req", line_t'(busy_o), line_t'(1'b1));
      chk("miss_ready_req", line_t'(miss_req_ready_o), line_t'(1'b0));
      chk("wb_ready_req", line_t'(wb_req_ready_o), line_t'(1'b0));
    end
    for (int i = 0; i <= d; i++) begin
      tick();
      refill_ready_i   = $urandom_range(0, 1);
      mem_req_ready_i  = $urandom_range(0, 1);
      mem_resp_valid_i = (i == d);
      mem_resp_data_i  = (i == d) ? rdata : rand_line();
      settle();
      chk("mem_req_valid_wait", line_t'(mem_req_valid_o), line_t'(1'b0));
      chk("refill_valid_wait", line_t'(refill_valid_o), line_t'(1'b0));
      chk("busy_wait", line_t'(busy_o), line_t'(1'b1));
    end
  endtask

  task automatic serve_refill(input int acc_cyc, input int exp_lat);
    for (int i = 0; i <= s_rr; i++) begin
      tick();
      refill_ready_i   = (i == s_rr);
      mem_req_ready_i  = $urandom_range(0, 1);
      mem_resp_valid_i = $urandom_range(0, 1);
      mem_resp_data_i  = rand_line();
      settle();
      if (i == 0) chk("refill_latency", line_t'(cyc - acc_cyc), line_t'(exp_lat));
      chk("refill_valid", line_t'(refill_valid_o), line_t'(1'b1));
      chk("refill_paddr", line_t'(refill_paddr_o), line_t'(s_miss_addr));
      chk("refill_way", line_t'(refill_way_o), line_t'(s_way));
      chk("refill_data", refill_data_o, s_rdata);
      chk("miss_ready_refill", line_t'(miss_req_ready_o), line_t'(1'b0));
      chk("mem_req_valid_refill", line_t'(mem_req_valid_o), line_t'(1'b0));
    end
  endtask

  // Model: writeback always wins; a pending miss waits for the full writeback to finish.
  task automatic run_scn();
    bit wb_pend;
    int acc;
    wb_pend   = s_wb;
    miss_pend = s_miss;
    while (wb_pend || miss_pend) begin
      tick();
      wb_req_valid_i        = wb_pend;
      wb_req_paddr_i        = s_wb_addr;
      wb_req_data_i         = s_wb_data;
      miss_req_valid_i      = miss_pend;
      miss_req_paddr_i      = s_miss_addr;
      miss_req_victim_way_i = s_way;
      miss_req_index_i      = s_idx;
      refill_ready_i        = $urandom_range(0, 1);
      mem_req_ready_i       = $urandom_range(0, 1);
      mem_resp_valid_i      = $urandom_range(0, 1);
      mem_resp_data_i       = rand_line();
      settle();
      acc = cyc;
      chk("busy_idle", line_t'(busy_o), line_t'(1'b0));
      chk("wb_ready_idle", line_t'(wb_req_ready_o), line_t'(1'b1));
      chk("miss_ready_idle", line_t'(miss_req_ready_o), line_t'(!wb_pend));
      chk("mem_req_valid_idle", line_t'(mem_req_valid_o), line_t'(1'b0));
      chk("refill_valid_idle", line_t'(refill_valid_o), line_t'(1'b0));
      if (wb_pend) begin
        wb_pend = 1'b0;
        serve_mem(1'b1, line_base(s_wb_addr), s_wb_data, s_kw, s_dw, rand_line());
      end else begin
        miss_pend = 1'b0;
        serve_mem(1'b0, line_base(s_miss_addr), '0, s_kr, s_dr, s_rdata);
        serve_refill(acc, 3 + s_kr + s_dr);
      end
    end
  endtask

  task automatic rand_scn();
    int sel;
    sel         = $urandom_range(0, 2);
    s_wb        = (sel != 1);
    s_miss      = (sel != 0);
    s_wb_addr   = PLEN'($urandom);
    s_miss_addr = ($urandom_range(0, 3) == 0) ? s_wb_addr : PLEN'($urandom);
    s_wb_data   = rand_line();
    s_rdata     = rand_line();
    s_way       = WAYW'($urandom);
    s_idx       = IDXW'($urandom);
    s_kw        = $urandom_range(0, 5);
    s_dw        = $urandom_range(0, 4);
    s_kr        = $urandom_range(0, 5);
    s_dr        = $urandom_range(0, 4);
    s_rr        = $urandom_range(0, 3);
  endtask

  task automatic reset_mid_read();
    int acc;
    tick();
    miss_req_valid_i      = 1'b1;
    miss_req_paddr_i      = 32'h9000_0ABC;
    miss_req_victim_way_i = 2'd3;
    miss_req_index_i      = '1;
    mem_req_ready_i       = 1'b0;
    mem_resp_valid_i      = 1'b0;
    settle();
    acc = cyc;
    chk("rst_test_accept", line_t'(miss_req_ready_o), line_t'(1'b1));
    tick();
    miss_req_valid_i = 1'b0;
    mem_req_ready_i  = 1'b1;
    settle();
    chk("rst_test_req", line_t'(mem_req_valid_o), line_t'(1'b1));
    tick();
    mem_req_ready_i = 1'b0;
    settle();
    chk("rst_test_wait_busy", line_t'(busy_o), line_t'(1'b1));
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_busy", line_t'(busy_o), line_t'(1'b0));
    chk("rst_refill_valid", line_t'(refill_valid_o), line_t'(1'b0));
    chk("rst_mem_req_valid", line_t'(mem_req_valid_o), line_t'(1'b0));
    chk("rst_refill_paddr", line_t'(refill_paddr_o), line_t'(0));
    chk("rst_refill_way", line_t'(refill_way_o), line_t'(0));
    tick();
    rst_ni           = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = rand_line();
    settle();
    chk("stray_resp_busy", line_t'(busy_o), line_t'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_resp_valid_i = 1'b0;
      settle();
      chk("stray_resp_no_refill", line_t'(refill_valid_o), line_t'(1'b0));
      chk("stray_resp_idle", line_t'(busy_o), line_t'(1'b0));
      chk("stray_resp_data", refill_data_o, line_t'(0));
    end
    if (acc < 0) chk("rst_test_acc", line_t'(acc), line_t'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni                = 1'b0;
    miss_req_valid_i      = 1'b0;
    miss_req_paddr_i      = '0;
    miss_req_victim_way_i = '0;
    miss_req_index_i      = '0;
    wb_req_valid_i        = 1'b0;
    wb_req_paddr_i        = '0;
    wb_req_data_i         = '0;
    refill_ready_i        = 1'b0;
    mem_req_ready_i       = 1'b0;
    mem_resp_valid_i      = 1'b0;
    mem_resp_data_i       = '0;
    miss_pend             = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_busy", line_t'(busy_o), line_t'(1'b0));
    chk("reset_refill_valid", line_t'(refill_valid_o), line_t'(1'b0));
    chk("reset_mem_req_valid", line_t'(mem_req_valid_o), line_t'(1'b0));
    chk("reset_refill_data", refill_data_o, line_t'(0));
    chk("reset_mem_addr", line_t'(mem_req_addr_o), line_t'(0));
    rst_ni = 1'b1;

    // Plain miss, response in the fourth wait cycle
    s_wb = 1'b0; s_miss = 1'b1;
    s_wb_addr = '0; s_wb_data = '0;
    s_miss_addr = 32'h8000_1234; s_way = 2'd2; s_idx = 6'h11;
    s_rdata = {LINE_BYTES{8'hA5}};
    s_kw = 0; s_dw = 0; s_kr = 0; s_dr = 3; s_rr = 0;
    run_scn();

    // Writeback and miss together, same line
    rand_scn();
    s_wb = 1'b1; s_miss = 1'b1;
    s_wb_addr = 32'h8000_0040; s_miss_addr = 32'h8000_0040;
    run_scn();

    // Memory not ready for five cycles, minimum-latency response
    rand_scn();
    s_wb = 1'b0; s_miss = 1'b1; s_kr = 5; s_dr = 0; s_rr = 0;
    run_scn();

    // Refill back-pressured for three cycles
    rand_scn();
    s_wb = 1'b0; s_miss = 1'b1; s_kr = 0; s_dr = 0; s_rr = 3;
    run_scn();

    reset_mid_read();

    // Serviced normally after the reset
    rand_scn();
    s_wb = 1'b0; s_miss = 1'b1;
    run_scn();

    for (int n = 0; n < 60; n++) begin
      rand_scn();
      run_scn();
    end

    tick();
    settle();
    chk("final_idle", line_t'(busy_o), line_t'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_mem_ctrl.md
DCACHE_MEM_CTRL -- requirements
Module: dcache_mem_ctrl

Interface
REQ-001 SHALL take parameter: Cfg, global_config_pkg::Cfg, which supplies PLEN, DCACHE_LINE_WIDTH, DCACHE_SET_ASSOC_WIDTH and DCACHE_INDEX_WIDTH.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- miss_req_valid_i / miss_req_ready_o  in/out  1  D-cache miss handshake.
- miss_req_paddr_i  in  PLEN  miss line address.
- miss_req_victim_way_i  in  DCACHE_SET_ASSOC_WIDTH  victim way.
- miss_req_index_i  in  DCACHE_INDEX_WIDTH  set index; latched and unused.
- wb_req_valid_i / wb_req_ready_o  in/out  1  writeback handshake.
- wb_req_paddr_i  in  PLEN  writeback line address.
- wb_req_data_i  in  LINE  dirty line.
- refill_valid_o / refill_ready_i  out/in  1  refill handshake.
- refill_paddr_o  out  PLEN  refill line address.
- refill_way_o  out  DCACHE_SET_ASSOC_WIDTH  refill way.
- refill_data_o  out  LINE  refill line data.
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake.
- mem_req_we_o  out  1  1 = line write, 0 = line read.
- mem_req_addr_o  out  PLEN  line-aligned address.
- mem_req_wdata_o  out  LINE  write data.
- mem_resp_valid_i  in  1  one-cycle response pulse.
- mem_resp_data_i  in  LINE  read data; ignored for writes.
- busy_o  out  1  high when state != IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, REFILL, with exactly one memory transaction outstanding.
REQ-004 IDLE SHALL assert wb_req_ready_o=1 and miss_req_ready_o=!wb_req_valid_i; a writeback takes fixed priority over a miss so victim data reaches memory before any re-read.
REQ-005 On an accepted handshake, the block SHALL latch all request fields in the same edge and move to WB_REQ (writeback) or RD_REQ (miss); both ready outputs SHALL be 0 in every other state.
REQ-006 The block SHALL drive mem_req_addr_o with the latched address, low log2(LINE/8) bits forced to 0.
REQ-007 WB_REQ / RD_REQ SHALL assert mem_req_valid_o with we=1 / we=0 and hold all mem_req fields stable until mem_req_ready_i; on fire, go to WB_WAIT / RD_WAIT.
REQ-008 WB_WAIT SHALL return to IDLE on mem_resp_valid_i.
REQ-009 RD_WAIT SHALL capture mem_resp_data_i on mem_resp_valid_i and go to REFILL.
REQ-010 REFILL SHALL assert refill_valid_o with the latched paddr and way and the captured data, held stable until refill_ready_i; on fire, return to IDLE.
REQ-011 mem_resp_valid_i outside WB_WAIT/RD_WAIT SHALL be ignored; a response in the same cycle as the mem_req fire SHALL also be ignored.
REQ-012 Minimum latency from miss accept to refill_valid_o, with mem_req_ready_i=1 and a response one cycle after the request fire, SHALL be 3 cycles.
REQ-013 A new request SHALL be acceptable in the cycle after return to IDLE; there are no back-to-back accepts in IDLE->IDLE.
REQ-014 Outputs SHALL be register- or state-decoded only; there is no combinational path from mem_resp_* to refill_*.

Reset
REQ-015 Assertion of rst_ni SHALL immediately force state to IDLE and all valid outputs, busy_o, and latched address, way and data registers to 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction; any late mem_resp_valid_i after reset SHALL be ignored per REQ-011.

Structure
REQ-017 The state enum dcache_mem_state_e SHALL live in the shared decode/config package next to the D-cache types.
REQ-018 The block SHALL be a single module with no sub-module; arbitration is fixed-priority inline.

Verification
REQ-019 Miss only, paddr 0x8000_1234, way 2, mem ready and response after 4 cycles with data 0xA5.. -> mem_req addr 0x8000_1200 (64B line), we=0; refill paddr 0x8000_1234, way 2, data 0xA5.., then IDLE.
REQ-020 Miss and writeback valid in the same IDLE cycle (wb 0x8000_0040, miss 0x8000_0040) -> write issued first with wb data; miss accepted only after the write response; read follows.
REQ-021 mem_req_ready_i low for 5 cycles -> mem_req_valid_o and fields stable for all 5 cycles; exactly one request fires.
REQ-022 refill_ready_i low for 3 cycles -> refill held stable; miss_req_ready_o stays 0 until refill fire +1 cycle.
REQ-023 rst_ni pulsed in RD_WAIT, then a stray mem_resp_valid_i -> no refill_valid_o, busy_o=0, next miss is serviced normally.
REQ-024 Spurious mem_resp_valid_i in IDLE and REFILL -> no state change, no data overwrite.
